vga_timing_gen: RTL
===================

Name: vga_timing_gen

Overview:
- Upstream stage of every graphic controller in the display path, including the score overlay.
- Generates the 640x480@60 Hz raster: pixel_x/pixel_y coordinates, hsync/vsync and video_on, plus a pixel-rate enable and line/frame pulses.
- Runs on the system clock and derives the pixel rate internally with a clock-enable divider, so all downstream controllers sit in one clock domain.

Parameters:
- H_DISPLAY, 640, visible pixels per line
- H_FRONT, 16, horizontal front porch (pixels)
- H_SYNC, 96, hsync pulse width (pixels)
- H_BACK, 48, horizontal back porch (pixels)
- V_DISPLAY, 480, visible lines per frame
- V_FRONT, 10, vertical front porch (lines)
- V_SYNC, 2, vsync pulse width (lines)
- V_BACK, 33, vertical back porch (lines)
- CLK_DIV, 2, pclk cycles per pixel (≥1); 50 MHz / 2 = 25 MHz pixel rate
- SYNC_ACTIVE, 0, active level of hsync/vsync (0 = active-low)

Ports:
- pclk  in  1  system clock; all logic on the rising edge
- reset  in  1  synchronous, active-high reset
- pixel_x  out  10  horizontal counter, 0..H_TOTAL-1
- pixel_y  out  10  vertical counter, 0..V_TOTAL-1
- hsync  out  1  horizontal sync, level SYNC_ACTIVE when asserted
- vsync  out  1  vertical sync, level SYNC_ACTIVE when asserted
- video_on  out  1  high when pixel_x<H_DISPLAY and pixel_y<V_DISPLAY
- pixel_tick  out  1  one-pclk pulse every CLK_DIV cycles; the counters advance on edges where it is high
- line_start  out  1  pixel_tick && pixel_x==0
- frame_start  out  1  pixel_tick && pixel_x==0 && pixel_y==0

Behaviour:
- Interface: one clock, pclk. Reset is synchronous and active-high.
- Derived widths:
  - H_TOTAL = sum of the H_* parameters (800).
  - V_TOTAL = sum of the V_* parameters (525).
  - Counters are 10 bits. Elaboration error if H_TOTAL or V_TOTAL > 1024.
- Divider:
  - div_cnt counts 0..CLK_DIV-1 and wraps.
  - pixel_tick = (div_cnt == CLK_DIV-1).
  - CLK_DIV=1: pixel_tick is constantly 1 outside reset.
- Horizontal counter: on an edge with pixel_tick=1, h_cnt increments; at H_TOTAL-1 it wraps to 0.
- Vertical counter: v_cnt increments only on the edge where h_cnt wraps; at V_TOTAL-1 it wraps to 0 on that same edge. Simultaneous h and v wrap (799,524) → (0,0).
- pixel_x/pixel_y are the counter registers themselves. No offset and no clamping in blanking.
- Registered decode:
  - hsync, vsync and video_on are registers.
  - Each loads the decode of the next-state counter values, so they stay cycle-aligned with pixel_x/pixel_y (zero relative latency).
  - hsync asserted for h in [H_DISPLAY+H_FRONT, H_DISPLAY+H_FRONT+H_SYNC-1] = [656,751].
  - vsync asserted for v in [490,491].
- Pulses: line_start and frame_start are decoded from the registered counters and pixel_tick. Each is exactly one pclk wide, once per line / per frame respectively.
- Reset:
  - div_cnt, h_cnt and v_cnt = 0.
  - hsync = vsync = !SYNC_ACTIVE (deasserted).
  - video_on, pixel_tick, line_start and frame_start = 0.
  - Reset asserted mid-frame takes effect on the next edge with no partial state kept.
- After reset release:
  - video_on goes to 1 on the first rising edge, because (0,0) is visible.
  - The first pixel_tick occurs CLK_DIV cycles after release. frame_start is asserted in that cycle.
- Frame period: H_TOTAL*V_TOTAL*CLK_DIV pclk cycles = 840000 with the default parameters.

Decomposition:
- Package vga_timing_pkg:
  - default timing constants
  - derived H_TOTAL/V_TOTAL
  - sync-window start/end constants
  - COORD_W = 10
  - all reused by the graphic controllers for bounds checks
- One sub-module, pixel_tick_gen: the CLK_DIV clock-enable divider with synchronous reset, also reusable by sprite animation timers.
- Counters and decode stay in the top module.

Test Plan:
- Reset then release, CLK_DIV=2:
  - During reset: pixel_x=pixel_y=0, hsync=vsync=1, video_on=0.
  - First edge after release: video_on=1.
  - Cycle 2: pixel_tick=1 and frame_start=1.
- Horizontal timing, run one line:
  - hsync low exactly for pixel_x 656..751, i.e. 96 ticks = 192 pclk.
  - video_on falls when pixel_x goes 639→640.
  - line_start once per 1600 pclk.
- Vertical timing, run a full frame:
  - vsync low only for pixel_y 490..491 (1600 ticks).
  - video_on=0 for all pixel_y≥480.
  - Consecutive frame_start pulses are 840000 pclk apart.
- Wrap boundary:
  - At (799,524), the next tick gives (0,0).
  - Same tick: frame_start=1, and hsync/vsync/video_on are consistent with (0,0): deasserted, deasserted, 1.
- Reset mid-frame:
  - Assert reset at (300,200) for 3 cycles.
  - Outputs return to their reset values on the next edge.
  - Counting restarts from (0,0) after release.
- Parameter variant, CLK_DIV=1, SYNC_ACTIVE=1:
  - pixel_tick constantly high.
  - Line = 800 pclk.
  - hsync high only for pixel_x 656..751.

Source files
------------

// File: rtl/vga_timing_pkg.sv
// -----------------------------------------------------------------------------
// vga_timing_pkg
// Shared raster constants for the display path. Holds the default 640x480@60
// timing, the derived line/frame totals, the sync-window bounds and the
// coordinate width used by every graphic controller for bounds checks.
// No ports (package).
// -----------------------------------------------------------------------------
package vga_timing_pkg;

  // Coordinate width shared by pixel_x / pixel_y and all consumers.
  localparam int unsigned COORD_W = 10;
  localparam int unsigned COORD_MAX_COUNT = 1 << COORD_W;

  typedef logic [COORD_W-1:0] coord_t;

  // Default horizontal timing (pixels).
  localparam int unsigned DEF_H_DISPLAY = 640;
  localparam int unsigned DEF_H_FRONT   = 16;
  localparam int unsigned DEF_H_SYNC    = 96;
  localparam int unsigned DEF_H_BACK    = 48;

  // Default vertical timing (lines).
  localparam int unsigned DEF_V_DISPLAY = 480;
  localparam int unsigned DEF_V_FRONT   = 10;
  localparam int unsigned DEF_V_SYNC    = 2;
  localparam int unsigned DEF_V_BACK    = 33;

  // Default pixel-rate divider and sync polarity (0 = active-low).
  localparam int unsigned DEF_CLK_DIV     = 2;
  localparam logic        DEF_SYNC_ACTIVE = 1'b0;

  // Derived totals for the default geometry.
  localparam int unsigned DEF_H_TOTAL =
    DEF_H_DISPLAY + DEF_H_FRONT + DEF_H_SYNC + DEF_H_BACK;
  localparam int unsigned DEF_V_TOTAL =
    DEF_V_DISPLAY + DEF_V_FRONT + DEF_V_SYNC + DEF_V_BACK;

  // Inclusive sync windows for the default geometry.
  localparam int unsigned DEF_H_SYNC_START = DEF_H_DISPLAY + DEF_H_FRONT;
  localparam int unsigned DEF_H_SYNC_END   = DEF_H_SYNC_START + DEF_H_SYNC - 1;
  localparam int unsigned DEF_V_SYNC_START = DEF_V_DISPLAY + DEF_V_FRONT;
  localparam int unsigned DEF_V_SYNC_END   = DEF_V_SYNC_START + DEF_V_SYNC - 1;

  // True when coordinate c lies in the inclusive range [lo, hi].
  function automatic logic in_window(coord_t c, coord_t lo, coord_t hi);
    return (c >= lo) && (c <= hi);
  endfunction

  // Pin level for a sync signal given its active level and whether asserted.
  function automatic logic sync_level(logic active, logic asserted);
    return asserted ? active : ~active;
  endfunction

endpackage

// File: rtl/pixel_tick_gen.sv
// -----------------------------------------------------------------------------
// pixel_tick_gen
// Clock-enable divider: emits a one-cycle tick every CLK_DIV clocks so that
// pixel-rate (or animation-rate) logic can run in the system clock domain.
// The tick is registered; the first tick appears CLK_DIV cycles after srst_i
// is released, and with CLK_DIV=1 it is constantly high outside reset.
//
// Ports:
//   clk_i   in  1  system clock, rising edge
//   srst_i  in  1  synchronous active-high reset
//   tick_o  out 1  one-clock enable pulse, period CLK_DIV
// -----------------------------------------------------------------------------
module pixel_tick_gen #(
  parameter int unsigned CLK_DIV = 2
) (
  input  logic clk_i,
  input  logic srst_i,
  output logic tick_o
);

  localparam int unsigned CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  typedef logic [CNT_W-1:0] cnt_t;

  localparam cnt_t CNT_LAST = cnt_t'(CLK_DIV - 1);
  localparam cnt_t CNT_ONE  = cnt_t'(1);

  if (CLK_DIV < 1) begin : g_clk_div_chk
    $error("pixel_tick_gen: CLK_DIV must be at least 1");
  end

  cnt_t div_cnt_q;
  cnt_t div_cnt_d;
  logic tick_q;

  // Divider next state: count 0..CLK_DIV-1 and wrap.
  always_comb begin
    div_cnt_d = div_cnt_q;
    if (div_cnt_q == CNT_LAST) begin
      div_cnt_d = '0;
    end else begin
      div_cnt_d = div_cnt_q + CNT_ONE;
    end
  end

  // Divider and tick registers. The tick registers the terminal count, which
  // delays it by one clock so the first tick lands CLK_DIV clocks after reset.
  always_ff @(posedge clk_i) begin
    if (srst_i) begin
      div_cnt_q <= '0;
      tick_q    <= 1'b0;
    end else begin
      div_cnt_q <= div_cnt_d;
      tick_q    <= (div_cnt_q == CNT_LAST);
    end
  end

  assign tick_o = tick_q;

endmodule

// File: rtl/vga_timing_gen.sv
// -----------------------------------------------------------------------------
// vga_timing_gen
// Raster timing generator for the display path. Derives the pixel rate from
// pclk with a clock-enable divider, runs the horizontal/vertical counters and
// produces registered sync/blanking decode aligned with the counters, plus
// line and frame start pulses.
//
// Ports:
//   pclk         in  1   system clock, rising edge
//   reset        in  1   synchronous active-high reset
//   pixel_x      out 10  horizontal counter, 0..H_TOTAL-1
//   pixel_y      out 10  vertical counter, 0..V_TOTAL-1
//   hsync        out 1   horizontal sync, level SYNC_ACTIVE when asserted
//   vsync        out 1   vertical sync, level SYNC_ACTIVE when asserted
//   video_on     out 1   high inside the visible area
//   pixel_tick   out 1   pixel-rate enable; counters advance on its edges
//   line_start   out 1   pixel_tick at pixel_x == 0
//   frame_start  out 1   pixel_tick at pixel_x == 0 and pixel_y == 0
// -----------------------------------------------------------------------------
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int unsigned H_DISPLAY   = DEF_H_DISPLAY,
  parameter int unsigned H_FRONT     = DEF_H_FRONT,
  parameter int unsigned H_SYNC      = DEF_H_SYNC,
  parameter int unsigned H_BACK      = DEF_H_BACK,
  parameter int unsigned V_DISPLAY   = DEF_V_DISPLAY,
  parameter int unsigned V_FRONT     = DEF_V_FRONT,
  parameter int unsigned V_SYNC      = DEF_V_SYNC,
  parameter int unsigned V_BACK      = DEF_V_BACK,
  parameter int unsigned CLK_DIV     = DEF_CLK_DIV,
  parameter logic        SYNC_ACTIVE = DEF_SYNC_ACTIVE
) (
  input  logic               pclk,
  input  logic               reset,
  output logic [COORD_W-1:0] pixel_x,
  output logic [COORD_W-1:0] pixel_y,
  output logic               hsync,
  output logic               vsync,
  output logic               video_on,
  output logic               pixel_tick,
  output logic               line_start,
  output logic               frame_start
);

  localparam int unsigned H_TOTAL = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
  localparam int unsigned V_TOTAL = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;

  if (H_TOTAL > COORD_MAX_COUNT) begin : g_h_total_chk
    $error("vga_timing_gen: H_TOTAL does not fit the coordinate counter");
  end
  if (V_TOTAL > COORD_MAX_COUNT) begin : g_v_total_chk
    $error("vga_timing_gen: V_TOTAL does not fit the coordinate counter");
  end

  localparam coord_t H_LAST    = coord_t'(H_TOTAL - 1);
  localparam coord_t V_LAST    = coord_t'(V_TOTAL - 1);
  localparam coord_t H_VISIBLE = coord_t'(H_DISPLAY);
  localparam coord_t V_VISIBLE = coord_t'(V_DISPLAY);
  localparam coord_t H_SYNC_LO = coord_t'(H_DISPLAY + H_FRONT);
  localparam coord_t H_SYNC_HI = coord_t'(H_DISPLAY + H_FRONT + H_SYNC - 1);
  localparam coord_t V_SYNC_LO = coord_t'(V_DISPLAY + V_FRONT);
  localparam coord_t V_SYNC_HI = coord_t'(V_DISPLAY + V_FRONT + V_SYNC - 1);
  localparam coord_t COORD_ONE = coord_t'(1);

  logic   tick_s;
  coord_t h_cnt_q;
  coord_t h_cnt_d;
  coord_t v_cnt_q;
  coord_t v_cnt_d;
  logic   hsync_q;
  logic   hsync_d;
  logic   vsync_q;
  logic   vsync_d;
  logic   video_on_q;
  logic   video_on_d;

  pixel_tick_gen #(
    .CLK_DIV (CLK_DIV)
  ) u_pixel_tick_gen (
    .clk_i  (pclk),
    .srst_i (reset),
    .tick_o (tick_s)
  );

  // Counter next state: h advances on each tick, v advances when h wraps.
  always_comb begin
    h_cnt_d = h_cnt_q;
    v_cnt_d = v_cnt_q;
    if (tick_s) begin
      if (h_cnt_q == H_LAST) begin
        h_cnt_d = '0;
        if (v_cnt_q == V_LAST) begin
          v_cnt_d = '0;
        end else begin
          v_cnt_d = v_cnt_q + COORD_ONE;
        end
      end else begin
        h_cnt_d = h_cnt_q + COORD_ONE;
        v_cnt_d = v_cnt_q;
      end
    end else begin
      h_cnt_d = h_cnt_q;
      v_cnt_d = v_cnt_q;
    end
  end

  // Decode of the next-state counters, so the registered flags line up with
  // the counter registers in the same cycle.
  always_comb begin
    hsync_d    = sync_level(SYNC_ACTIVE, in_window(h_cnt_d, H_SYNC_LO, H_SYNC_HI));
    vsync_d    = sync_level(SYNC_ACTIVE, in_window(v_cnt_d, V_SYNC_LO, V_SYNC_HI));
    video_on_d = (h_cnt_d < H_VISIBLE) && (v_cnt_d < V_VISIBLE);
  end

  // Counter and decode registers.
  always_ff @(posedge pclk) begin
    if (reset) begin
      h_cnt_q    <= '0;
      v_cnt_q    <= '0;
      hsync_q    <= ~SYNC_ACTIVE;
      vsync_q    <= ~SYNC_ACTIVE;
      video_on_q <= 1'b0;
    end else begin
      h_cnt_q    <= h_cnt_d;
      v_cnt_q    <= v_cnt_d;
      hsync_q    <= hsync_d;
      vsync_q    <= vsync_d;
      video_on_q <= video_on_d;
    end
  end

  assign pixel_x    = h_cnt_q;
  assign pixel_y    = v_cnt_q;
  assign hsync      = hsync_q;
  assign vsync      = vsync_q;
  assign video_on   = video_on_q;
  assign pixel_tick = tick_s;

  // Pulses are gated by the registered tick, so each is one pclk wide.
  assign line_start  = tick_s && (h_cnt_q == '0);
  assign frame_start = tick_s && (h_cnt_q == '0) && (v_cnt_q == '0);

endmodule
